// File: rtl/decode_sequencer_if.sv
// Bus bundle between the decode run controller and its clients / SRAM controller.
// The master modport is the controller view; the slave modport is the client side.
interface decode_sequencer_if #(
    parameter int unsigned ADDR_W = 18
);
    logic              Go;
    logic              UART_done;
    logic [ADDR_W-1:0] UART_addr;
    logic [15:0]       UART_wdata;
    logic              UART_we_n;
    logic [ADDR_W-1:0] M2_addr;
    logic [15:0]       M2_wdata;
    logic              M2_we_n;
    logic [ADDR_W-1:0] M1_addr;
    logic [15:0]       M1_wdata;
    logic              M1_we_n;
    logic [ADDR_W-1:0] VGA_addr;
    logic              M2_Stop;
    logic              M1_Stop;

    logic              M2_Start;
    logic              M1_Start;
    logic              Client_resetn;
    logic [ADDR_W-1:0] SRAM_address;
    logic [15:0]       SRAM_write_data;
    logic              SRAM_we_n;
    logic              VGA_enable;
    logic              Busy;
    logic              Error;
    logic [2:0]        Stage;

    modport master (
        input  Go, UART_done, UART_addr, UART_wdata, UART_we_n,
        input  M2_addr, M2_wdata, M2_we_n, M1_addr, M1_wdata, M1_we_n,
        input  VGA_addr, M2_Stop, M1_Stop,
        output M2_Start, M1_Start, Client_resetn, SRAM_address, SRAM_write_data,
        output SRAM_we_n, VGA_enable, Busy, Error, Stage
    );

    modport slave (
        output Go, UART_done, UART_addr, UART_wdata, UART_we_n,
        output M2_addr, M2_wdata, M2_we_n, M1_addr, M1_wdata, M1_we_n,
        output VGA_addr, M2_Stop, M1_Stop,
        input  M2_Start, M1_Start, Client_resetn, SRAM_address, SRAM_write_data,
        input  SRAM_we_n, VGA_enable, Busy, Error, Stage
    );
endinterface

// File: rtl/decode_sequencer.sv
// Run controller for the decode path: UART upload -> M2 -> M1 -> VGA, owning the single SRAM port.
// The SRAM mux is registered; gap states insert a no-write bubble at each ownership change.
module decode_sequencer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd4000000,
    parameter bit          BYPASS_M2      = 1'b0,
    parameter int unsigned ADDR_W         = 18
) (
    input logic                Clock,
    input logic                Reset,
    decode_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StUart = 3'd1,
        StGap1 = 3'd2,
        StM2   = 3'd3,
        StGap2 = 3'd4,
        StM1   = 3'd5,
        StDone = 3'd6,
        StErr  = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic              go_q;
    logic [1:0]        rearm_q, rearm_d;
    logic [31:0]       tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              we_n_q, we_n_d;
    logic              go_edge, timeout, counting;

    assign go_edge  = bus.Go & ~go_q;
    assign timeout  = (tmo_q == TIMEOUT_CYCLES - 32'd1);
    assign counting = (state_q == StUart) || (state_q == StM2) || (state_q == StM1);

    always_comb begin
        state_d = state_q;
        rearm_d = rearm_q;
        // rearm_q counts down the two Client_resetn-low cycles before a new run starts
        if (rearm_q != 2'd0) begin
            rearm_d = rearm_q - 2'd1;
            if (rearm_q == 2'd1) state_d = StUart;
        end else begin
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (go_edge) rearm_d = 2'd2;
                end
                StUart: begin
                    if (bus.UART_done)  state_d = BYPASS_M2 ? StGap2 : StGap1;
                    else if (timeout)   state_d = StErr;
                end
                StGap1: state_d = StM2;
                StM2: begin
                    if (bus.M2_Stop)    state_d = StGap2;
                    else if (timeout)   state_d = StErr;
                end
                StGap2: state_d = StM1;
                StM1: begin
                    if (bus.M1_Stop)    state_d = StDone;
                    else if (timeout)   state_d = StErr;
                end
            endcase
        end
    end

    always_comb begin
        if (state_d != state_q) tmo_d = '0;
        else if (counting)      tmo_d = tmo_q + 32'd1;
        else                    tmo_d = tmo_q;
    end

    // Owner follows the current state; the request is registered onto the SRAM port.
    always_comb begin
        addr_d = '0;
        data_d = '0;
        we_n_d = 1'b1;
        unique case (state_q)
            StUart: begin
                addr_d = bus.UART_addr;
                data_d = bus.UART_wdata;
                we_n_d = bus.UART_we_n;
            end
            StM2: begin
                addr_d = bus.M2_addr;
                data_d = bus.M2_wdata;
                we_n_d = bus.M2_we_n;
            end
            StM1: begin
                addr_d = bus.M1_addr;
                data_d = bus.M1_wdata;
                we_n_d = bus.M1_we_n;
            end
            StDone: addr_d = bus.VGA_addr;
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            go_q    <= 1'b0;
            rearm_q <= 2'd0;
            tmo_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            go_q    <= bus.Go;
            rearm_q <= rearm_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_n_q  <= we_n_d;
        end
    end

    assign bus.M2_Start        = (state_q == StM2) & ~bus.M2_Stop;
    assign bus.M1_Start        = (state_q == StM1) & ~bus.M1_Stop;
    assign bus.Client_resetn   = (rearm_q == 2'd0);
    assign bus.SRAM_address    = addr_q;
    assign bus.SRAM_write_data = data_q;
    assign bus.SRAM_we_n       = we_n_q;
    assign bus.VGA_enable      = (state_q == StDone);
    assign bus.Busy            = (state_q != StIdle) && (state_q != StDone) && (state_q != StErr);
    assign bus.Error           = (state_q == StErr);
    assign bus.Stage           = state_q;
endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer: three parameterisations plus an SRAM-port scoreboard on dut_a.
module tb_decode_sequencer;
    localparam int unsigned AW = 18;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    decode_sequencer_if #(.ADDR_W(AW)) ia ();
    decode_sequencer_if #(.ADDR_W(AW)) ib ();
    decode_sequencer_if #(.ADDR_W(AW)) ic ();

    decode_sequencer #(.TIMEOUT_CYCLES(32'd1000), .BYPASS_M2(1'b0), .ADDR_W(AW)) dut_a (
        .Clock(Clock), .Reset(Reset), .bus(ia.master));
    decode_sequencer #(.TIMEOUT_CYCLES(32'd100), .BYPASS_M2(1'b0), .ADDR_W(AW)) dut_b (
        .Clock(Clock), .Reset(Reset), .bus(ib.master));
    decode_sequencer #(.TIMEOUT_CYCLES(32'd1000), .BYPASS_M2(1'b1), .ADDR_W(AW)) dut_c (
        .Clock(Clock), .Reset(Reset), .bus(ic.master));

    typedef struct packed {
        logic          chk_data;
        logic          we_n;
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } sb_t;

    int   tests = 0;
    int   fails = 0;
    int   sel   = 0;
    sb_t  sbq[$];
    bit   sb_en = 1'b0;
    bit   saw_3ffff = 1'b0;
    bit   c_saw_m2  = 1'b0;
    logic [2:0] stage_sel;

    assign stage_sel = (sel == 0) ? ia.Stage : (sel == 1) ? ib.Stage : ic.Stage;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_stage(input logic [2:0] exp, input int budget, input string tag);
        int n = 0;
        while (stage_sel !== exp && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(stage_sel), 32'(exp));
    endtask

    task automatic idle_inputs();
        ia.Go = 0; ia.UART_done = 0; ia.M2_Stop = 0; ia.M1_Stop = 0; ia.VGA_addr = '0;
        ia.UART_we_n = 1; ia.UART_addr = '0; ia.UART_wdata = '0;
        ia.M2_we_n = 1; ia.M2_addr = '0; ia.M2_wdata = '0;
        ia.M1_we_n = 1; ia.M1_addr = '0; ia.M1_wdata = '0;
        ib.Go = 0; ib.UART_done = 0; ib.M2_Stop = 0; ib.M1_Stop = 0; ib.VGA_addr = '0;
        ib.UART_we_n = 1; ib.UART_addr = '0; ib.UART_wdata = '0;
        ib.M2_we_n = 1; ib.M2_addr = '0; ib.M2_wdata = '0;
        ib.M1_we_n = 1; ib.M1_addr = '0; ib.M1_wdata = '0;
        ic.Go = 0; ic.UART_done = 0; ic.M2_Stop = 0; ic.M1_Stop = 0; ic.VGA_addr = '0;
        ic.UART_we_n = 1; ic.UART_addr = '0; ic.UART_wdata = '0;
        ic.M2_we_n = 1; ic.M2_addr = '0; ic.M2_wdata = '0;
        ic.M1_we_n = 1; ic.M1_addr = '0; ic.M1_wdata = '0;
    endtask

    // Expected SRAM port for cycle t is pushed at t and compared at t+1.
    always @(negedge Clock) begin
        sb_t e;
        sb_t n;
        if (sb_en) begin
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("sb_we_n", 32'(ia.SRAM_we_n), 32'(e.we_n));
                check("sb_addr", 32'(ia.SRAM_address), 32'(e.addr));
                if (e.chk_data) check("sb_data", 32'(ia.SRAM_write_data), 32'(e.data));
            end
            case (ia.Stage)
                3'd1:    n = {1'b1, ia.UART_we_n, ia.UART_addr, ia.UART_wdata};
                3'd3:    n = {1'b1, ia.M2_we_n, ia.M2_addr, ia.M2_wdata};
                3'd5:    n = {1'b1, ia.M1_we_n, ia.M1_addr, ia.M1_wdata};
                3'd6:    n = {1'b0, 1'b1, ia.VGA_addr, 16'h0000};
                default: n = {1'b1, 1'b1, {AW{1'b0}}, 16'h0000};
            endcase
            sbq.push_back(n);
        end
        if ((ia.Stage == 3'd3 || ia.Stage == 3'd4) && ia.SRAM_address == 18'h3FFFF) saw_3ffff = 1;
        if (ic.M2_Start || ic.Stage == 3'd2 || ic.Stage == 3'd3) c_saw_m2 = 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        idle_inputs();
        repeat (3) step();
        check("rst_stage", 32'(ia.Stage), 32'd0);
        check("rst_we_n", 32'(ia.SRAM_we_n), 32'd1);
        check("rst_cresetn", 32'(ia.Client_resetn), 32'd1);
        check("rst_busy", 32'(ia.Busy), 32'd0);
        check("rst_error", 32'(ia.Error), 32'd0);
        check("rst_vga", 32'(ia.VGA_enable), 32'd0);
        check("rst_addr", 32'(ia.SRAM_address), 32'd0);
        check("rst_m2start", 32'(ia.M2_Start), 32'd0);
        Reset = 1'b0;
        step();
        sb_en = 1'b1;
        step();

        // T1 full run on dut_a
        ia.Go = 1; step();
        check("t1_cres_lo0", 32'(ia.Client_resetn), 32'd0);
        check("t1_idle_in_rearm", 32'(ia.Stage), 32'd0);
        ia.Go = 0; step();
        check("t1_cres_lo1", 32'(ia.Client_resetn), 32'd0);
        step();
        check("t1_cres_hi", 32'(ia.Client_resetn), 32'd1);
        check("t1_uart", 32'(ia.Stage), 32'd1);
        check("t1_busy", 32'(ia.Busy), 32'd1);
        ia.UART_we_n = 0;
        for (int i = 0; i < 46; i++) begin
            ia.UART_addr = 18'($urandom); ia.UART_wdata = 16'($urandom);
            ia.M2_we_n = 1'($urandom); ia.M2_addr = 18'($urandom);
            step();
        end
        ia.UART_done = 1; step();
        check("t1_gap1", 32'(ia.Stage), 32'd2);
        ia.UART_done = 0; ia.UART_we_n = 1; ia.M2_we_n = 0; ia.M2_addr = 18'h00ABC;
        step();
        check("t1_m2", 32'(ia.Stage), 32'd3);
        check("t1_gap1_no_write", 32'(ia.SRAM_we_n), 32'd1);
        check("t1_m2_start", 32'(ia.M2_Start), 32'd1);

        // T2 ownership inside S_M2
        ia.M1_we_n = 0; ia.M1_addr = 18'h3FFFF;
        ia.M2_addr = 18'd146944; ia.M2_wdata = 16'hBEEF; ia.M2_we_n = 0;
        step();
        check("t2_addr", 32'(ia.SRAM_address), 32'd146944);
        check("t2_we_n", 32'(ia.SRAM_we_n), 32'd0);
        check("t2_data", 32'(ia.SRAM_write_data), 32'h0000BEEF);
        for (int i = 0; i < 140; i++) begin
            ia.M2_addr = 18'($urandom_range(0, 18'h3FFFE)); ia.M2_wdata = 16'($urandom);
            ia.M2_we_n = 1'($urandom);
            step();
        end
        ia.M2_we_n = 0;
        ia.M2_Stop = 1; #1;
        check("t1_m2start_drop", 32'(ia.M2_Start), 32'd0);
        step();
        check("t1_gap2", 32'(ia.Stage), 32'd4);
        ia.M1_we_n = 1; ia.M1_addr = 18'h00155;
        step();
        check("t1_m1", 32'(ia.Stage), 32'd5);
        check("t1_gap2_no_write", 32'(ia.SRAM_we_n), 32'd1);
        check("t1_m1_start", 32'(ia.M1_Start), 32'd1);
        check("t2_never_3ffff", 32'(saw_3ffff), 32'd0);

        // T5 Go edge inside S_M1 has no effect
        ia.Go = 1; step();
        check("t5_go_ignored", 32'(ia.Stage), 32'd5);
        check("t5_go_no_rearm", 32'(ia.Client_resetn), 32'd1);
        ia.Go = 0;
        for (int i = 0; i < 190; i++) begin
            ia.M1_addr = 18'($urandom); ia.M1_wdata = 16'($urandom); ia.M1_we_n = 1'($urandom);
            step();
        end
        ia.M1_Stop = 1; #1;
        check("t1_m1start_drop", 32'(ia.M1_Start), 32'd0);
        step();
        check("t1_done", 32'(ia.Stage), 32'd6);
        check("t1_vga_en", 32'(ia.VGA_enable), 32'd1);
        check("t1_done_busy", 32'(ia.Busy), 32'd0);
        ia.VGA_addr = 18'h01234; ia.M1_we_n = 0;
        step();
        check("t1_vga_en_next", 32'(ia.VGA_enable), 32'd1);
        check("t1_vga_addr", 32'(ia.SRAM_address), 32'h01234);
        check("t1_done_we_n", 32'(ia.SRAM_we_n), 32'd1);

        // T3 timeout in S_M1 on dut_b (TIMEOUT_CYCLES=100)
        sel = 1;
        ib.Go = 1; step(); ib.Go = 0;
        wait_stage(3'd1, 5, "t3_uart");
        repeat (5) step();
        ib.UART_done = 1; step(); ib.UART_done = 0;
        wait_stage(3'd3, 3, "t3_m2");
        repeat (3) step();
        ib.M2_Stop = 1; step();
        wait_stage(3'd5, 3, "t3_m1_entry");
        ib.M1_we_n = 0;
        repeat (99) step();
        check("t3_m1_at_99", 32'(ib.Stage), 32'd5);
        step();
        check("t3_err_at_100", 32'(ib.Stage), 32'd7);
        check("t3_error", 32'(ib.Error), 32'd1);
        check("t3_m1start", 32'(ib.M1_Start), 32'd0);
        check("t3_busy", 32'(ib.Busy), 32'd0);
        step();
        check("t3_err_we_n", 32'(ib.SRAM_we_n), 32'd1);
        ib.Go = 1; ib.M2_Stop = 0; ib.M1_Stop = 0; ib.M1_we_n = 1; step();
        check("t3_cres_lo0", 32'(ib.Client_resetn), 32'd0);
        check("t3_err_held", 32'(ib.Stage), 32'd7);
        ib.Go = 0; step();
        check("t3_cres_lo1", 32'(ib.Client_resetn), 32'd0);
        step();
        check("t3_restart", 32'(ib.Stage), 32'd1);
        check("t3_cres_hi", 32'(ib.Client_resetn), 32'd1);
        check("t3_error_clr", 32'(ib.Error), 32'd0);

        // T5 Stop and timeout in the same cycle of S_M2
        repeat (3) step();
        ib.UART_done = 1; step(); ib.UART_done = 0;
        wait_stage(3'd3, 3, "t5_m2_entry");
        repeat (99) step();
        ib.M2_Stop = 1; step();
        check("t5_stop_wins", 32'(ib.Stage), 32'd4);
        check("t5_no_error", 32'(ib.Error), 32'd0);
        step();
        check("t5_m1", 32'(ib.Stage), 32'd5);

        // T4 bypass on dut_c
        sel = 2;
        ic.Go = 1; step(); ic.Go = 0;
        wait_stage(3'd1, 5, "t4_uart");
        repeat (4) step();
        ic.UART_done = 1; step(); ic.UART_done = 0;
        check("t4_gap2", 32'(ic.Stage), 32'd4);
        check("t4_m2start", 32'(ic.M2_Start), 32'd0);
        step();
        check("t4_m1", 32'(ic.Stage), 32'd5);
        check("t4_m1start", 32'(ic.M1_Start), 32'd1);
        ic.M1_Stop = 1; step();
        check("t4_done", 32'(ic.Stage), 32'd6);
        check("t4_no_m2", 32'(c_saw_m2), 32'd0);

        // T6 reset in the middle of S_M1 on dut_a
        sel = 0;
        ia.Go = 1; ia.M1_Stop = 0; ia.M2_Stop = 0; ia.M1_we_n = 1; step(); ia.Go = 0;
        wait_stage(3'd1, 4, "t6_uart");
        ia.UART_done = 1; step(); ia.UART_done = 0;
        wait_stage(3'd3, 3, "t6_m2");
        ia.M2_Stop = 1; step();
        wait_stage(3'd5, 3, "t6_m1");
        ia.M1_we_n = 0; ia.M1_addr = 18'h2AAAA; step();
        check("t6_write_fwd", 32'(ia.SRAM_we_n), 32'd0);
        sb_en = 1'b0;
        Reset = 1'b1; #1;
        check("t6_we_n_async", 32'(ia.SRAM_we_n), 32'd1);
        check("t6_stage_async", 32'(ia.Stage), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_hold_stage", 32'(ia.Stage), 32'd0);
            check("t6_hold_we_n", 32'(ia.SRAM_we_n), 32'd1);
            check("t6_hold_m1start", 32'(ia.M1_Start), 32'd0);
            check("t6_hold_busy", 32'(ia.Busy), 32'd0);
        end
        Reset = 1'b0;
        sbq.delete();
        step();
        sb_en = 1'b1;
        repeat (3) step();
        check("t6_idle_after", 32'(ia.Stage), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
